clk_div_monitor: RTL and testbench
==================================

// Module: clk_div_monitor
// PURPOSE
//  Receive-side checker for the divided-clock generator: samples clks[NUM_CLKS-1:0] on clk
//  and checks each one for its ideal divide-by-2^(i+1) period. Reports per-channel lock,
//  sticky error, and a saturating failure count.
//  Sits beside the generator in the clock bench and in the synthesised top as a self-check.
// PARAMETERS
//  NUM_CLKS    3   number of monitored divided clocks; channel i expects half-period HP_i = 2^i clk cycles
//  LOCK_CNT    4   consecutive good half-periods needed to declare lock (>=1)
//  ERR_CNT_W   8   width of err_count
// PORTS
//  clk        in   1          reference clock; every register updates on posedge
//  reset      in   1          synchronous, active-high reset
//  clks       in   NUM_CLKS   divided clocks under test; asynchronous to this block, edges sampled only
//  locked     out  NUM_CLKS   channel i is in LOCKED
//  all_locked out  1          &locked
//  err        out  NUM_CLKS   sticky: channel i has entered FAIL since reset
//  phase_err  out  NUM_CLKS   sticky phase violation (PHASE_CHECK_EN only, else 0)
//  err_count  out  ERR_CNT_W  total FAIL entries, all channels; saturates at all-ones
// BEHAVIOUR
//  - reset=1 at a posedge clears all state and outputs to 0, forces all channels to IDLE,
//    and loads s/s_prev with 0. Applies mid-operation too; outputs are 0 on the next cycle.
//  - Sampling: s <= clks each cycle, s_prev <= s. Per-channel edge e_i = s[i]^s_prev[i].
//  - Per-channel run counter cnt_i (width >= NUM_CLKS+1, saturating): 1 on edge cycle, else +1.
//    cnt_i is the number of cycles the current sampled level has held, including this cycle.
//  - Per-channel FSM, updated at the posedge after the cycle being evaluated:
//    IDLE  : e_i -> TRACK, good_i=0; no edge -> stay (no timeout in IDLE)
//    TRACK : e_i & cnt_i==HP_i -> good_i+1; if good_i+1==LOCK_CNT -> LOCKED
//            e_i & cnt_i!=HP_i -> FAIL
//            !e_i & cnt_i==HP_i -> FAIL (timeout: level would exceed HP_i)
//    LOCKED: the same good/bad/timeout checks apply; any bad -> FAIL; good -> stay
//    FAIL  : e_i -> TRACK, good_i=0 (restart); timeout ignored in FAIL
//  - On any transition into FAIL: err[i]<=1 and err_count+1, saturating.
//    Simultaneous FAIL entries on k channels in one cycle add k, saturating.
//  - Latency: a clks change seen at posedge t is in s at t, and its edge is evaluated at t.
//    locked/err change at posedge t+1, two clk edges after the input transition.
//  - HP_0=1: clks[0] must toggle on every sample. Any repeated level -> FAIL.
//  - Lock time for channel i from its first edge: LOCK_CNT*HP_i cycles.
//  - locked[i] drops in the same cycle err[i] sets. err and phase_err clear only on reset.
// CONFIGURATION
//  PHASE_CHECK_EN defined:
//    - For i>=1, an edge on s[i] is legal only in a cycle where s[i-1] falls (s_prev=1, s=0).
//    - Otherwise: phase_err[i]<=1 and channel i -> FAIL, counted as above.
//    - Ripple or counter-style divider alignment is enforced.
//    - Channel 0 has no phase check.
//  PHASE_CHECK_EN undefined:
//    - No phase logic; phase_err is tied to 0. Periods alone decide lock.
// TESTING
//  1 reset 3 cyc, then clks = bits[2:0] of a free-running counter (ideal divider)
//    -> locked=3'b111 and all_locked=1 within 24 cycles; err=0, err_count=0.
//  2 after lock, hold clks[1] at 0 -> locked[1]=0 and err[1]=1 two cycles after the missed toggle;
//    err_count=1; other channels stay locked.
//  3 after lock, repeat one clks[0] level for 1 extra cycle -> err[0]=1, err_count+=1;
//    once toggling resumes, locked[0]=1 again after 1+LOCK_CNT edges.
//  4 assert reset for 1 cycle while all_locked=1 -> every output 0 next cycle;
//    relock as in scenario 1.
//  5 clks[2] toggles on rising instead of falling edges of clks[1] (period still 8)
//    -> with PHASE_CHECK_EN: phase_err[2]=1, err[2]=1, locked[2]=0;
//       without: locked[2]=1, phase_err=0.
//  6 ERR_CNT_W=8, clks[0] stuck with a toggle every 3rd cycle for 2000 cycles -> err_count=255, no wrap.

Source files
------------

// File: rtl/clk_div_monitor.sv
// Receive-side period checker for divide-by-2^(i+1) clocks: per-channel lock, sticky error, fail count.
// Optional build macro PHASE_CHECK_EN adds divider-alignment checking (phase_err).
module clk_div_monitor #(
   parameter int unsigned NUM_CLKS  = 3,
   parameter int unsigned LOCK_CNT  = 4,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_CLKS-1:0]  clks,
   output logic [NUM_CLKS-1:0]  locked,
   output logic                 all_locked,
   output logic [NUM_CLKS-1:0]  err,
   output logic [NUM_CLKS-1:0]  phase_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int unsigned CNT_W  = NUM_CLKS + 1;
   localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int unsigned ADD_W  = $clog2(NUM_CLKS + 1);
   localparam int unsigned SUM_W  = ERR_CNT_W + ADD_W;

   typedef enum logic [1:0] {IDLE, TRACK, LOCKED, FAIL} state_t;

   logic [NUM_CLKS-1:0]  s, s_prev, edge_det, phase_bad, fail_entry;
   logic [CNT_W-1:0]     cnt      [NUM_CLKS];
   logic [CNT_W-1:0]     cnt_nxt  [NUM_CLKS];
   logic [GOOD_W-1:0]    good     [NUM_CLKS];
   logic [GOOD_W-1:0]    good_nxt [NUM_CLKS];
   state_t               state    [NUM_CLKS];
   state_t               state_nxt[NUM_CLKS];
   logic [ADD_W-1:0]     n_fail;
   logic [SUM_W-1:0]     sum;
   logic [ERR_CNT_W-1:0] err_count_nxt;

   assign edge_det = s ^ s_prev;

`ifdef PHASE_CHECK_EN
   logic [NUM_CLKS-1:0] fall;
   assign fall = s_prev & ~s;

   always_comb begin
      phase_bad = '0;
      for (int unsigned i = 1; i < NUM_CLKS; i++) begin
         phase_bad[i] = edge_det[i] & ~fall[i-1];
      end
   end
`else
   assign phase_bad = '0;
`endif

   // cnt holds the level length up to the previous cycle, so at an edge it is the
   // length of the level just ended and without an edge it flags a level about to overrun.
   always_comb begin
      for (int unsigned i = 0; i < NUM_CLKS; i++) begin
         state_nxt[i]  = state[i];
         good_nxt[i]   = good[i];
         fail_entry[i] = 1'b0;
         cnt_nxt[i]    = edge_det[i] ? CNT_W'(1) : ((&cnt[i]) ? cnt[i] : cnt[i] + 1'b1);
         case (state[i])
            IDLE, FAIL: begin
               if (edge_det[i]) begin
                  state_nxt[i] = TRACK;
                  good_nxt[i]  = '0;
               end
            end
            TRACK, LOCKED: begin
               if (edge_det[i] && (cnt[i] == (CNT_W'(1) << i)) && !phase_bad[i]) begin
                  if (state[i] == TRACK) begin
                     good_nxt[i] = good[i] + 1'b1;
                     if (good[i] + 1'b1 == GOOD_W'(LOCK_CNT)) state_nxt[i] = LOCKED;
                  end
               end else if (edge_det[i] || (cnt[i] == (CNT_W'(1) << i))) begin
                  state_nxt[i]  = FAIL;
                  fail_entry[i] = 1'b1;
               end
            end
            default: state_nxt[i] = IDLE;
         endcase
      end
   end

   always_comb begin
      n_fail = '0;
      for (int unsigned i = 0; i < NUM_CLKS; i++) begin
         n_fail = n_fail + ADD_W'(fail_entry[i]);
      end
      sum           = SUM_W'(err_count) + SUM_W'(n_fail);
      err_count_nxt = (sum > SUM_W'({ERR_CNT_W{1'b1}})) ? '1 : sum[ERR_CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s         <= '0;
         s_prev    <= '0;
         err       <= '0;
         err_count <= '0;
         for (int unsigned i = 0; i < NUM_CLKS; i++) begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
            good[i]  <= '0;
         end
      end else begin
         s         <= clks;
         s_prev    <= s;
         err       <= err | fail_entry;
         err_count <= err_count_nxt;
         for (int unsigned i = 0; i < NUM_CLKS; i++) begin
            state[i] <= state_nxt[i];
            cnt[i]   <= cnt_nxt[i];
            good[i]  <= good_nxt[i];
         end
      end
   end

`ifdef PHASE_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset) phase_err <= '0;
      else       phase_err <= phase_err | (fail_entry & phase_bad);
   end
`else
   assign phase_err = '0;
`endif

   always_comb begin
      for (int unsigned i = 0; i < NUM_CLKS; i++) begin
         locked[i] = (state[i] == LOCKED);
      end
   end

   assign all_locked = &locked;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Self-checking bench for clk_div_monitor: directed scenarios with randomized offsets/noise
// against an edge-timestamp reference model. Honours PHASE_CHECK_EN like the design.
module tb_clk_div_monitor;

   localparam int unsigned N  = 3;
   localparam int unsigned LC = 4;
   localparam int unsigned EW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  clks;
   logic [N-1:0]  locked, err, phase_err;
   logic          all_locked;
   logic [EW-1:0] err_count;

   int checks   = 0;
   int failures = 0;

   // Reference model: streak<0 means waiting for an edge, otherwise number of good
   // half-periods since the last restart; last[] is the cycle index of the latest edge.
   int            streak[N];
   longint        last[N];
   longint        cyc;
   logic [N-1:0]  prev;
   logic [N-1:0]  m_err, m_perr;
   int            m_fails;

   always #5 clk = ~clk;

   clk_div_monitor #(
      .NUM_CLKS (N),
      .LOCK_CNT (LC),
      .ERR_CNT_W(EW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clks      (clks),
      .locked    (locked),
      .all_locked(all_locked),
      .err       (err),
      .phase_err (phase_err),
      .err_count (err_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] m_locked();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = (streak[i] >= int'(LC));
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         streak[i] = -1;
         last[i]   = 0;
      end
      cyc     = 0;
      prev    = '0;
      m_err   = '0;
      m_perr  = '0;
      m_fails = 0;
   endtask

   task automatic model_eval(input logic [N-1:0] v);
      longint hp, gap;
      logic   edg, ok_phase;
      cyc++;
      for (int i = 0; i < N; i++) begin
         hp       = longint'(1) << i;
         edg      = (v[i] != prev[i]);
         ok_phase = 1'b1;
`ifdef PHASE_CHECK_EN
         if (i > 0 && edg) ok_phase = prev[i-1] && !v[i-1];
`endif
         if (streak[i] < 0) begin
            if (edg) begin
               streak[i] = 0;
               last[i]   = cyc;
            end
         end else begin
            gap = cyc - last[i];
            if (edg && gap == hp && ok_phase) begin
               streak[i]++;
               last[i] = cyc;
            end else if (edg || gap == hp) begin
               streak[i] = -1;
               m_err[i]  = 1'b1;
               m_fails++;
               if (edg && !ok_phase) m_perr[i] = 1'b1;
            end
         end
      end
      prev = v;
   endtask

   task automatic step(input logic [N-1:0] v, input logic rst);
      logic [N-1:0] ml;
      @(negedge clk);
      clks  = v;
      reset = rst;
      @(posedge clk);
      #1;
      if (rst) model_reset();
      ml = m_locked();
      chk("locked",     32'(locked),     32'(ml));
      chk("all_locked", 32'(all_locked), 32'(&ml));
      chk("err",        32'(err),        32'(m_err));
      chk("phase_err",  32'(phase_err),  32'(m_perr));
      chk("err_count",  32'(err_count),  (m_fails > 255) ? 32'd255 : 32'(m_fails));
      if (!rst) model_eval(v);
   endtask

   initial begin
      int           c, n, fails_before;
      logic [N-1:0] inv, v;
      logic         b0;

      clks  = '0;
      reset = 1'b1;
      model_reset();

      // 1: reset, then ideal divider from counter value 0
      repeat (3) step('0, 1'b1);
      chk("s1_reset_count", 32'(err_count), 32'd0);
      c = 0;
      for (int k = 0; k < 24; k++) begin step(c[2:0], 1'b0); c++; end
      chk("s1_all_locked", 32'(all_locked), 32'd1);
      chk("s1_err", 32'(err), 32'd0);
      for (int k = 0; k < 8; k++) begin step(c[2:0], 1'b0); c++; end

      // 2: hold clks[1] low long enough to miss a toggle
      n = 4 + int'($urandom_range(0, 3));
      for (int k = 0; k < n; k++) begin
         v = c[2:0]; v[1] = 1'b0; step(v, 1'b0); c++;
      end
      for (int k = 0; k < 2; k++) begin step(c[2:0], 1'b0); c++; end
      chk("s2_err1", 32'(err[1]), 32'd1);
      chk("s2_locked2", 32'(locked[2]), 32'd1);
      for (int k = 0; k < 30; k++) begin step(c[2:0], 1'b0); c++; end

      // 3: repeat one clks[0] level, then keep toggling with shifted phase
      fails_before = m_fails;
      inv = 3'b001;
      step(c[2:0] ^ inv, 1'b0);
      step(c[2:0] ^ inv, 1'b0); c++;
      for (int k = 0; k < 10; k++) begin step(c[2:0] ^ inv, 1'b0); c++; end
      chk("s3_err0", 32'(err[0]), 32'd1);
      chk("s3_relock0", 32'(locked[0]), 32'd1);
      chk("s3_count_grew", 32'(err_count > EW'(fails_before)), 32'd1);

      // 4: one-cycle reset mid-operation, relock from a random counter offset
      step(c[2:0] ^ inv, 1'b1);
      chk("s4_zero", 32'({locked, all_locked, err, phase_err, err_count}), 32'd0);
      c   = int'($urandom_range(0, 7));
      inv = '0;
      for (int k = 0; k < 30; k++) begin step(c[2:0], 1'b0); c++; end
      chk("s4_relocked", 32'(all_locked), 32'd1);

      // 5: clks[2] toggles on rising edges of clks[1]
      for (int k = 0; k < 40; k++) begin
         n = c + 2;
         v = {n[2], c[1], c[0]};
         step(v, 1'b0); c++;
      end
`ifdef PHASE_CHECK_EN
      chk("s5_phase_err2", 32'(phase_err[2]), 32'd1);
      chk("s5_unlocked2", 32'(locked[2]), 32'd0);
`else
      chk("s5_locked2", 32'(locked[2]), 32'd1);
      chk("s5_no_phase", 32'(phase_err), 32'd0);
`endif

      // random noise with occasional resets
      step('0, 1'b1);
      for (int k = 0; k < 200; k++) begin
         v = N'($urandom);
         step(v, ($urandom_range(0, 39) == 0));
      end

      // 6: clks[0] toggles every 3rd cycle; err_count must saturate
      step('0, 1'b1);
      b0 = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         if (k % 3 == 2) b0 = ~b0;
         step({2'b00, b0}, 1'b0);
      end
      chk("s6_saturated", 32'(err_count), 32'd255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
